rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
- Registered, rotating-priority, multi-grant priority encoder.
- Each load cycle it selects up to NUM_OUTS set request bits out of N, searching in rotated order from a priority pointer. It presents the selections as index/onehot outputs behind a valid/ready handshake.
- Successor to the combinational fixed-priority encoder. Used by issue, dispatch and memory-arbitration stages that need fairness, more than one winner per cycle, and a pipeline register.

Parameters:
- N, 8, number of request lines; legal 2..64.
- NUM_OUTS, 1, grants per cycle; legal 1..N.
- REVERSE, 0, 0 = search ascending from pointer; 1 = search descending from pointer.
- LN, LOG2UP(N), index width; derived, never overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- requests  in  N  request vector, sampled on load cycles.
- grant_valid  out  NUM_OUTS  per-slot valid of the registered grant.
- grant_index  out  NUM_OUTS*LN  per-slot granted index; slot k occupies bits [k*LN +: LN].
- grant_onehot  out  N  OR of all valid slot onehots.
- grant_any  out  1  OR of grant_valid.
- grant_ready  in  1  consumer accepts the current registered grant.
- ptr  out  LN  current priority pointer (debug/visibility).

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - grant_valid = 0, grant_index = 0, grant_onehot = 0, grant_any = 0.
  - ptr = 0 when REVERSE=0; ptr = N-1 when REVERSE=1.
- load = (~grant_any) | grant_ready. The output register and ptr update only on load cycles.
- Selection:
  - Rotated order starts at ptr and steps +1 mod N (REVERSE=0) or -1 mod N (REVERSE=1).
  - Slot k receives the (k+1)-th set bit of requests in that order.
  - Slots with no remaining set bit get valid=0 and index=0.
  - Slots fill contiguously from slot 0; no gaps.
- Latency: requests sampled on a load edge appear on the outputs the following cycle. No combinational path from requests or grant_ready to any output.
- Pointer update on a load cycle with at least one grant:
  - ptr = (index of last valid slot + 1) mod N for REVERSE=0.
  - ptr = (index of last valid slot - 1) mod N for REVERSE=1.
  - On a load cycle with no requests, ptr holds.
- Stall: grant_any=1 and grant_ready=0 → outputs and ptr hold exactly.
  - requests changing during a stall are ignored.
  - A request dropped mid-stall may still appear granted; the upstream must tolerate this.
- Bubble: grant_any=0 loads every cycle regardless of grant_ready.
- Wrap-around:
  - ptr = N-1 (REVERSE=0) wraps the search to 0 after N-1.
  - Pointer arithmetic is mod N, and N need not be a power of two. Correct wrap is required for N=5, 6, 7.
- Full saturation: all N bits set and NUM_OUTS=N → every slot valid, grant_onehot all ones, ptr returns to its own value (last slot + 1 mod N).
- Reset asserted mid-stall → reset values on the next edge; the pending grant is discarded.

Optional Feature:
- Macro: RR_PRIORITY_ENCODER_PERF_EN.
- When defined, three extra output ports are added, each 32-bit, saturating, and cleared by reset:
  - perf_grants: total valid slots accepted on handshake cycles (grant_any & grant_ready).
  - perf_stalls: cycles with grant_any=1 and grant_ready=0.
  - perf_starve: cycles in which a request bit stays set while unserved for more than N consecutive load cycles. One global age counter tracks the oldest unserved bit at ptr.
- When not defined: ports and counters are absent, and the core behaviour is bit-identical.

Decomposition:
- Package rr_pe_pkg holds:
  - Localparam function for mod-N increment/decrement.
  - Constant PERF_CTR_W=32.
  - No typedefs dependent on N; width-dependent types stay local.
- One combinational sub-module, rr_pe_select, takes requests, ptr and REVERSE and produces per-slot valid/index/onehot plus next_ptr.
  - Implementation: rotate the request vector, run a sequential multi-pick, unrotate.
- The top module contains only the register stage, the handshake and the perf block.

Test Plan:
- Reset then requests=8'b1010_0100, N=8, NUM_OUTS=1, grant_ready=1 → cycle 1: index=2; after that load ptr=3; next loads index=5, then 7, then 2 (wrap).
- N=8, NUM_OUTS=2, requests=8'hFF held, ready=1 → grants {0,1},{2,3},{4,5},{6,7},{0,1}; ptr sequence 0,2,4,6,0.
- Stall: grant index=3 valid, grant_ready=0 for 5 cycles while requests change to 8'h01 → outputs and ptr stable; on ready=1 the next grant is index 0.
- N=5, REVERSE=1, requests=5'b10001, ptr reset 4 → grants 4, then 0, then 4; ptr 3, then 4 (wrap from 0 to 4), then 3.
- requests=0 with ready=1 for 3 cycles → grant_any=0, ptr held at its value; then requests=8'h80 → grant index 7 one cycle later.
- Reset asserted during a stall with grant_any=1 → next cycle all outputs 0 and ptr at reset value. With PERF_EN defined: perf_stalls counts exactly the stalled cycles before reset, then reads 0.

Source files
------------

// File: rtl/rr_pe_pkg.sv
// Shared helpers for the rotating-priority encoder: modular pointer arithmetic
// and the performance-counter width.
package rr_pe_pkg;

  localparam int PERF_CTR_W = 32;

  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  function automatic int mod_dec(input int v, input int n);
    return (v == 0) ? n - 1 : v - 1;
  endfunction

  // d must be below n; works for any n, not only powers of two
  function automatic int mod_add(input int v, input int d, input int n);
    return (v + d >= n) ? v + d - n : v + d;
  endfunction

  function automatic int mod_sub(input int v, input int d, input int n);
    return (v >= d) ? v - d : v - d + n;
  endfunction

endpackage

// File: rtl/rr_pe_select.sv
// Combinational multi-grant selector: rotates requests to start at ptr, picks
// up to NUM_OUTS set bits in order, and maps them back to absolute indices.
module rr_pe_select
  import rr_pe_pkg::*;
#(
  parameter int N        = 8,
  parameter int NUM_OUTS = 1,
  parameter int REVERSE  = 0,
  localparam int LN      = $clog2(N)
) (
  input  logic [N-1:0]           requests,
  input  logic [LN-1:0]          ptr,
  output logic [NUM_OUTS-1:0]    slot_valid,
  output logic [NUM_OUTS*LN-1:0] slot_index,
  output logic [N-1:0]           slot_onehot,
  output logic [LN-1:0]          next_ptr
);

  logic [LN-1:0] rot_idx [N];
  logic [N-1:0]  rot_req;
  logic [N-1:0]  remaining;
  logic [LN-1:0] last_idx;
  logic          found;
  logic          any_pick;

  // rot_idx[j] is the absolute request line searched j-th from ptr
  always_comb begin
    rot_req = '0;
    for (int j = 0; j < N; j++) begin
      rot_idx[j] = LN'((REVERSE != 0) ? mod_sub(int'(ptr), j, N)
                                      : mod_add(int'(ptr), j, N));
      rot_req[j] = requests[rot_idx[j]];
    end
  end

  always_comb begin
    slot_valid  = '0;
    slot_index  = '0;
    slot_onehot = '0;
    remaining   = rot_req;
    last_idx    = ptr;
    found       = 1'b0;
    any_pick    = 1'b0;
    for (int k = 0; k < NUM_OUTS; k++) begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (!found && remaining[j]) begin
          found                    = 1'b1;
          remaining[j]             = 1'b0;
          slot_valid[k]            = 1'b1;
          slot_index[k*LN +: LN]   = rot_idx[j];
          slot_onehot[rot_idx[j]]  = 1'b1;
          last_idx                 = rot_idx[j];
          any_pick                 = 1'b1;
        end
      end
    end
    next_ptr = any_pick ? LN'((REVERSE != 0) ? mod_dec(int'(last_idx), N)
                                             : mod_inc(int'(last_idx), N))
                        : ptr;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered rotating-priority multi-grant encoder with valid/ready output.
// Define RR_PRIORITY_ENCODER_PERF_EN to add grant/stall/starvation counters.
module rr_priority_encoder
  import rr_pe_pkg::*;
#(
  parameter int N        = 8,
  parameter int NUM_OUTS = 1,
  parameter int REVERSE  = 0,
  localparam int LN      = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           requests,
  output logic [NUM_OUTS-1:0]    grant_valid,
  output logic [NUM_OUTS*LN-1:0] grant_index,
  output logic [N-1:0]           grant_onehot,
  output logic                   grant_any,
  input  logic                   grant_ready,
  output logic [LN-1:0]          ptr
`ifdef RR_PRIORITY_ENCODER_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]  perf_grants,
  output logic [PERF_CTR_W-1:0]  perf_stalls,
  output logic [PERF_CTR_W-1:0]  perf_starve
`endif
);

  localparam logic [LN-1:0] PTR_RST = LN'((REVERSE != 0) ? N - 1 : 0);

  logic [NUM_OUTS-1:0]    sel_valid, valid_d, valid_q;
  logic [NUM_OUTS*LN-1:0] sel_index, index_d, index_q;
  logic [N-1:0]           sel_onehot, onehot_d, onehot_q;
  logic [LN-1:0]          sel_ptr, ptr_d, ptr_q;
  logic                   load;

  rr_pe_select #(
    .N        (N),
    .NUM_OUTS (NUM_OUTS),
    .REVERSE  (REVERSE)
  ) u_select (
    .requests    (requests),
    .ptr         (ptr_q),
    .slot_valid  (sel_valid),
    .slot_index  (sel_index),
    .slot_onehot (sel_onehot),
    .next_ptr    (sel_ptr)
  );

  // An empty register always loads, so bubbles never wait on grant_ready
  assign load = ~grant_any | grant_ready;

  always_comb begin
    valid_d  = valid_q;
    index_d  = index_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if (load) begin
      valid_d  = sel_valid;
      index_d  = sel_index;
      onehot_d = sel_onehot;
      ptr_d    = sel_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      index_q  <= '0;
      onehot_q <= '0;
      ptr_q    <= PTR_RST;
    end else begin
      valid_q  <= valid_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_index  = index_q;
  assign grant_onehot = onehot_q;
  assign grant_any    = |valid_q;
  assign ptr          = ptr_q;

`ifdef RR_PRIORITY_ENCODER_PERF_EN
  logic [PERF_CTR_W-1:0] grants_d, grants_q, stalls_d, stalls_q;
  logic [PERF_CTR_W-1:0] starve_d, starve_q, age_d, age_q, pop_cnt;
  logic                  unserved;

  function automatic logic [PERF_CTR_W-1:0] sat_add(input logic [PERF_CTR_W-1:0] a,
                                                    input logic [PERF_CTR_W-1:0] b);
    logic [PERF_CTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_CTR_W] ? '1 : s[PERF_CTR_W-1:0];
  endfunction

  // age_q counts consecutive load cycles that leave some request unserved
  always_comb begin
    pop_cnt = '0;
    for (int k = 0; k < NUM_OUTS; k++) pop_cnt = pop_cnt + PERF_CTR_W'(valid_q[k]);
    unserved = |(requests & ~sel_onehot);
    grants_d = grants_q;
    stalls_d = stalls_q;
    starve_d = starve_q;
    age_d    = age_q;
    if (grant_any && grant_ready)  grants_d = sat_add(grants_q, pop_cnt);
    if (grant_any && !grant_ready) stalls_d = sat_add(stalls_q, PERF_CTR_W'(1));
    if (load) age_d = unserved ? sat_add(age_q, PERF_CTR_W'(1)) : '0;
    if (age_q > PERF_CTR_W'(N)) starve_d = sat_add(starve_q, PERF_CTR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grants_q <= '0;
      stalls_q <= '0;
      starve_q <= '0;
      age_q    <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
      starve_q <= starve_d;
      age_q    <= age_d;
    end
  end

  assign perf_grants = grants_q;
  assign perf_stalls = stalls_q;
  assign perf_starve = starve_q;
`endif

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: three configurations share a clock;
// stimulus queues expected grants, a monitor pops them on each handshake.
module tb_rr_priority_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rst2;
  logic [7:0] req0, req1;
  logic [4:0] req2;
  logic       rdy0, rdy1, rdy2;

  logic [0:0] gv0; logic [2:0] gi0; logic [7:0] go0; logic ga0; logic [2:0] p0;
  logic [1:0] gv1; logic [5:0] gi1; logic [7:0] go1; logic ga1; logic [2:0] p1;
  logic [0:0] gv2; logic [2:0] gi2; logic [4:0] go2; logic ga2; logic [2:0] p2;
`ifdef RR_PRIORITY_ENCODER_PERF_EN
  logic [31:0] pg0, ps0, pv0, pg1, ps1, pv1, pg2, ps2, pv2;
  logic [31:0] s0;
`endif

  rr_priority_encoder #(.N(8), .NUM_OUTS(1), .REVERSE(0)) u0 (
    .clk(clk), .reset(rst0), .requests(req0), .grant_valid(gv0), .grant_index(gi0),
    .grant_onehot(go0), .grant_any(ga0), .grant_ready(rdy0), .ptr(p0)
`ifdef RR_PRIORITY_ENCODER_PERF_EN
    , .perf_grants(pg0), .perf_stalls(ps0), .perf_starve(pv0)
`endif
  );

  rr_priority_encoder #(.N(8), .NUM_OUTS(2), .REVERSE(0)) u1 (
    .clk(clk), .reset(rst1), .requests(req1), .grant_valid(gv1), .grant_index(gi1),
    .grant_onehot(go1), .grant_any(ga1), .grant_ready(rdy1), .ptr(p1)
`ifdef RR_PRIORITY_ENCODER_PERF_EN
    , .perf_grants(pg1), .perf_stalls(ps1), .perf_starve(pv1)
`endif
  );

  rr_priority_encoder #(.N(5), .NUM_OUTS(1), .REVERSE(1)) u2 (
    .clk(clk), .reset(rst2), .requests(req2), .grant_valid(gv2), .grant_index(gi2),
    .grant_onehot(go2), .grant_any(ga2), .grant_ready(rdy2), .ptr(p2)
`ifdef RR_PRIORITY_ENCODER_PERF_EN
    , .perf_grants(pg2), .perf_stalls(ps2), .perf_starve(pv2)
`endif
  );

  typedef struct {
    logic [63:0] vld;
    logic [63:0] idx;
    logic [63:0] oh;
    logic [63:0] ptr;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [63:0] v, input logic [63:0] i,
                      input logic [63:0] o, input logic [63:0] p);
    exp_t e;
    e.vld = v; e.idx = i; e.oh = o; e.ptr = p;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input int d, input logic [63:0] v, input logic [63:0] i,
                         input logic [63:0] o, input logic [63:0] p);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d_unexpected_grant got idx=%0h oh=%0h expected=none at %0t", d, i, o, $time);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("u%0d_valid", d), v, e.vld);
      chk($sformatf("u%0d_index", d), i, e.idx);
      chk($sformatf("u%0d_onehot", d), o, e.oh);
      chk($sformatf("u%0d_ptr", d), p, e.ptr);
    end
  endtask

  // Monitor: every accepted grant must match the head of its queue
  initial begin
    forever begin
      @(negedge clk);
      if (ga0 && rdy0) pop_cmp(0, 64'(gv0), 64'(gi0), 64'(go0), 64'(p0));
      if (ga1 && rdy1) pop_cmp(1, 64'(gv1), 64'(gi1), 64'(go1), 64'(p1));
      if (ga2 && rdy2) pop_cmp(2, 64'(gv2), 64'(gi2), 64'(go2), 64'(p2));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    req0 = '0; req1 = '0; req2 = '0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_any0", 64'(ga0), 0);
    chk("rst_valid0", 64'(gv0), 0);
    chk("rst_index0", 64'(gi0), 0);
    chk("rst_onehot0", 64'(go0), 0);
    chk("rst_ptr0", 64'(p0), 0);
    chk("rst_valid1", 64'(gv1), 0);
    chk("rst_ptr2", 64'(p2), 4);
    tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // u0: rotating single grant with wrap
    req0 = 8'b1010_0100;
    push(0, 1, 2, 8'h04, 3);
    push(0, 1, 5, 8'h20, 6);
    push(0, 1, 7, 8'h80, 0);
    push(0, 1, 2, 8'h04, 3);
    repeat (4) tick();
    req0 = '0;

    // u0: bubbles hold ptr
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("bubble_any0", 64'(ga0), 0);
      chk("bubble_ptr0", 64'(p0), 3);
    end
    tick();
    req0 = 8'h80;
    push(0, 1, 7, 8'h80, 0);
    tick();
    req0 = '0;
    tick();

    // u0: stall holds everything while requests change
    rdy0 = 1'b0;
    req0 = 8'h08;
    tick();
    req0 = 8'h01;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid0", 64'(gv0), 1);
      chk("stall_index0", 64'(gi0), 3);
      chk("stall_ptr0", 64'(p0), 4);
    end
    tick();
    push(0, 1, 3, 8'h08, 4);
    push(0, 1, 0, 8'h01, 1);
    rdy0 = 1'b1;
    tick();
    req0 = '0;
    tick();

    // u0: reset during a stall discards the pending grant
    rdy0 = 1'b0;
    req0 = 8'h10;
    tick();
    req0 = '0;
    @(negedge clk);
    chk("pre_rst_index0", 64'(gi0), 4);
    chk("pre_rst_ptr0", 64'(p0), 5);
`ifdef RR_PRIORITY_ENCODER_PERF_EN
    s0 = ps0;
`endif
    repeat (3) tick();
`ifdef RR_PRIORITY_ENCODER_PERF_EN
    @(negedge clk);
    chk("perf_stalls0", 64'(ps0), 64'(s0) + 3);
`endif
    rst0 = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_any0", 64'(ga0), 0);
    chk("midrst_valid0", 64'(gv0), 0);
    chk("midrst_index0", 64'(gi0), 0);
    chk("midrst_onehot0", 64'(go0), 0);
    chk("midrst_ptr0", 64'(p0), 0);
`ifdef RR_PRIORITY_ENCODER_PERF_EN
    chk("midrst_perf_stalls0", 64'(ps0), 0);
`endif
    tick();
    rst0 = 1'b0;
    rdy0 = 1'b1;

    // u1: two grants per cycle, saturated input, then wrap and partial fill
    req1 = 8'hFF;
    push(1, 2'b11, 64'(6'o10), 8'h03, 2);
    push(1, 2'b11, 64'(6'o32), 8'h0C, 4);
    push(1, 2'b11, 64'(6'o54), 8'h30, 6);
    push(1, 2'b11, 64'(6'o76), 8'hC0, 0);
    push(1, 2'b11, 64'(6'o10), 8'h03, 2);
    repeat (5) tick();
    req1 = '0;
    tick();
    req1 = 8'h81;
    push(1, 2'b11, 64'(6'o07), 8'h81, 1);
    push(1, 2'b01, 64'(6'o02), 8'h04, 3);
    tick();
    req1 = 8'h04;
    tick();
    req1 = '0;

    // u2: N=5 descending search with mod-5 wrap
    req2 = 5'b10001;
    push(2, 1, 4, 5'h10, 3);
    push(2, 1, 0, 5'h01, 4);
    push(2, 1, 4, 5'h10, 3);
    repeat (3) tick();
    req2 = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("idle_ptr2", 64'(p2), 3);
    chk("drain_q0", 64'(q0.size()), 0);
    chk("drain_q1", 64'(q1.size()), 0);
    chk("drain_q2", 64'(q2.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
